// File: rtl/demux_1x2_buf_pkg.sv
// Shared definitions for the 1-to-2 buffered demultiplexer.
//   - DefaultDataWidth / DefaultDepth: parameter defaults used by the top level.
//   - out_sel_e: decoded meaning of the in_sel input.
package demux_1x2_buf_pkg;

  localparam int unsigned DefaultDataWidth = 32;
  localparam int unsigned DefaultDepth     = 2;

  // in_sel encoding: 0 steers to out0, 1 steers to out1.
  typedef enum logic {
    SelOut0 = 1'b0,
    SelOut1 = 1'b1
  } out_sel_e;

endpackage

// File: rtl/demux_1x2_buf_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset; clears pointers, count and storage
//   push  - write wdata this cycle (ignored while full)
//   wdata - word to write
//   full  - count equals DEPTH
//   pop   - discard the head word this cycle (ignored while empty)
//   rdata - head word, read from storage at the read pointer
//   empty - count equals zero
module sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [CntW-1:0]       count_q, count_d;

  logic push_en;
  logic pop_en;

  assign full  = (count_q == DepthCnt);
  assign empty = (count_q == '0);
  assign rdata = mem_q[rptr_q];

  // A full FIFO refuses a push even when it pops in the same cycle.
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_en) begin
      mem_d[wptr_q] = wdata;
      // DEPTH is a power of two, so the pointer wraps naturally.
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop_en) begin
      rptr_d = rptr_q + 1'b1;
    end
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/demux_1x2_buf.sv
// 1-to-2 demultiplexer with a FIFO on each output.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   in_data/in_sel        - word and destination (1 -> out1, 0 -> out0)
//   in_valid/in_ready     - input handshake; in_ready reflects only the selected FIFO's fill
//   out0_* / out1_*       - valid/ready output streams, head of FIFO 0 / FIFO 1
module demux_1x2_buf
  import demux_1x2_buf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned DEPTH      = DefaultDepth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready
);

  out_sel_e sel;
  logic     full0, full1;
  logic     empty0, empty1;
  logic     push0, push1;
  logic     accept;

  assign sel = out_sel_e'(in_sel);

  // Readiness depends only on the selected FIFO's registered fill level,
  // never on the downstream ready, so a stall blocks only its own path.
  always_comb begin
    in_ready = 1'b0;
    unique case (sel)
      SelOut0: in_ready = ~full0;
      SelOut1: in_ready = ~full1;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;
  assign push0  = accept & (sel == SelOut0);
  assign push1  = accept & (sel == SelOut1);

  assign out0_valid = ~empty0;
  assign out1_valid = ~empty1;

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo0 (
    .clk  (clk),
    .rst  (rst),
    .push (push0),
    .wdata(in_data),
    .full (full0),
    .pop  (out0_ready),
    .rdata(out0_data),
    .empty(empty0)
  );

  sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_fifo1 (
    .clk  (clk),
    .rst  (rst),
    .push (push1),
    .wdata(in_data),
    .full (full1),
    .pop  (out1_ready),
    .rdata(out1_data),
    .empty(empty1)
  );

endmodule

// File: tb/tb_demux_1x2_buf.sv
// Self-checking bench for demux_1x2_buf: directed scenarios plus random traffic,
// checked against a queue-based model of the two output buffers.
module tb_demux_1x2_buf;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [DW-1:0] out1_data;
  logic          out1_valid;
  logic          out1_ready;

  always #5 clk = ~clk;

  demux_1x2_buf #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out0_data (out0_data),
    .out0_valid(out0_valid),
    .out0_ready(out0_ready),
    .out1_data (out1_data),
    .out1_valid(out1_valid),
    .out1_ready(out1_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model: one queue per output; storage is all-zero until first write after reset.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  bit            pristine0 = 1'b1;
  bit            pristine1 = 1'b1;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check_eq("out0_valid", {31'b0, out0_valid}, {31'b0, q0.size() != 0});
    check_eq("out1_valid", {31'b0, out1_valid}, {31'b0, q1.size() != 0});
    if (q0.size() != 0)  check_eq("out0_data", out0_data, q0[0]);
    else if (pristine0)  check_eq("out0_data_zero", out0_data, '0);
    if (q1.size() != 0)  check_eq("out1_data", out1_data, q1[0]);
    else if (pristine1)  check_eq("out1_data_zero", out1_data, '0);
  endtask

  // One clock cycle: drive at negedge, check just after, update model at posedge.
  // rdy_obs returns the DUT's in_ready seen during the cycle.
  task automatic cycle(input logic v, input logic s, input logic [DW-1:0] d,
                       input logic r0, input logic r1, output logic rdy_obs);
    logic exp_ready;
    logic acc;
    @(negedge clk);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    exp_ready = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check_eq("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    check_outputs();
    rdy_obs = in_ready;
    acc     = v && exp_ready;
    @(posedge clk);
    if (r0 && q0.size() != 0) void'(q0.pop_front());
    if (r1 && q1.size() != 0) void'(q1.pop_front());
    if (acc) begin
      if (s) begin q1.push_back(d); pristine1 = 1'b0; end
      else   begin q0.push_back(d); pristine0 = 1'b0; end
    end
  endtask

  // Reset with live traffic on the inputs: reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    in_valid   = 1'b1;
    in_sel     = 1'($urandom);
    in_data    = $urandom;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    @(posedge clk);
    q0.delete();
    q1.delete();
    pristine0 = 1'b1;
    pristine1 = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sel   = 1'b0;
    #1;
    check_eq("rst_ready_sel0", {31'b0, in_ready}, 32'd1);
    check_outputs();
    in_sel = 1'b1;
    #1;
    check_eq("rst_ready_sel1", {31'b0, in_ready}, 32'd1);
  endtask

  logic rdy;

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    // Idle after reset.
    repeat (2) cycle(1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, rdy);

    // One word to each output; each appears one cycle after its push.
    cycle(1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, rdy);
    cycle(1'b1, 1'b0, 32'h5555_0000, 1'b0, 1'b0, rdy);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, rdy);

    // Stalled out1: third push refused, out0 path still flows.
    cycle(1'b1, 1'b1, 32'h1111_0001, 1'b0, 1'b0, rdy);
    cycle(1'b1, 1'b1, 32'h1111_0002, 1'b0, 1'b0, rdy);
    cycle(1'b1, 1'b1, 32'h1111_0003, 1'b0, 1'b0, rdy);
    check_eq("stall1_third_refused", {31'b0, rdy}, 32'd0);
    cycle(1'b1, 1'b0, 32'h2222_0001, 1'b0, 1'b0, rdy);
    check_eq("stall1_other_accepted", {31'b0, rdy}, 32'd1);
    cycle(1'b1, 1'b0, 32'h2222_0002, 1'b0, 1'b0, rdy);

    // Both full: pop and push out0 together -> push refused, then accepted.
    cycle(1'b1, 1'b0, 32'h2222_0003, 1'b1, 1'b0, rdy);
    check_eq("full_pop_push_refused", {31'b0, rdy}, 32'd0);
    cycle(1'b1, 1'b0, 32'h2222_0003, 1'b0, 1'b0, rdy);
    check_eq("after_pop_push_accepted", {31'b0, rdy}, 32'd1);
    repeat (4) cycle(1'b0, 1'b0, '0, 1'b1, 1'b1, rdy);

    // Stream 1..10 into out0 at full rate.
    for (int i = 1; i <= 10; i++) begin
      cycle(1'b1, 1'b0, DW'(i), 1'b1, 1'b0, rdy);
      check_eq("stream_accept", {31'b0, rdy}, 32'd1);
    end
    repeat (2) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0, rdy);

    // Reset while both hold words.
    cycle(1'b1, 1'b0, 32'h3333_0001, 1'b0, 1'b0, rdy);
    cycle(1'b1, 1'b1, 32'h3333_0002, 1'b0, 1'b0, rdy);
    do_reset();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0), rdy);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_1x2_buf.md
DEMUX_1X2_BUF -- requirements
Module: demux_1x2_buf

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 32: width of every data port.
REQ-002 Parameter DEPTH SHALL default to 2: entries per output FIFO; legal values are powers of 2 that are at least 2.
REQ-003 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous and active-high.
REQ-005 Port in_data  input  DATA_WIDTH: word to be routed.
REQ-006 Port in_sel  input  1: destination select; 1 routes to out1, 0 routes to out0.
REQ-007 Port in_valid  input  1: in_data and in_sel are valid.
REQ-008 Port in_ready  output  1: block accepts the word this cycle.
REQ-009 Port out1_data  output  DATA_WIDTH: head word of FIFO 1.
REQ-010 Port out1_valid  output  1: FIFO 1 is non-empty.
REQ-011 Port out1_ready  input  1: consumer 1 takes the head word.
REQ-012 Ports out0_data, out0_valid and out0_ready SHALL mirror REQ-009 to REQ-011 for FIFO 0.

Function
REQ-013 Accept: a push SHALL occur when in_valid=1 and in_ready=1; the word SHALL be written to the FIFO chosen by in_sel.
REQ-014 in_ready SHALL equal NOT full of the FIFO chosen by in_sel; it SHALL be combinational from in_sel and registered counts only.
REQ-015 in_ready SHALL NOT depend on out*_ready; a full FIFO SHALL refuse a push even in a cycle where it pops.
REQ-016 Pop: FIFO k SHALL pop when outk_valid=1 and outk_ready=1.
REQ-017 outk_valid SHALL be 1 exactly when count_k is not 0.
REQ-018 outk_data SHALL be the entry at read pointer k, read combinationally from registered storage.
REQ-019 Latency: a word pushed at edge N SHALL be presented with outk_valid=1 in the cycle after edge N; there is no same-cycle bypass.
REQ-020 Order SHALL be preserved within each output; no ordering is guaranteed between out0 and out1.
REQ-021 Each count SHALL be clog2(DEPTH)+1 bits wide; read and write pointers SHALL be clog2(DEPTH) bits wide and wrap modulo DEPTH.
REQ-022 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave its count unchanged.
REQ-023 Simultaneous push and pop on an empty FIFO cannot occur, since valid=0.
REQ-024 A push to one FIFO and a pop from the other in the same cycle SHALL both take effect independently.
REQ-025 A stalled output (outk_ready=0) SHALL hold outk_valid and outk_data stable.
REQ-026 A stalled output SHALL block only pushes selecting that output; the other path SHALL keep flowing.
REQ-027 in_valid=0 SHALL cause no state change on the input side; in_sel and in_data are don't-care.

Reset
REQ-028 When rst=1 at a rising edge, all counts and pointers SHALL clear to 0 and all storage entries SHALL clear to 0.
REQ-029 After reset, out0_valid=out1_valid=0, out0_data=out1_data=0, and in_ready=1 for either in_sel.
REQ-030 Reset SHALL override any same-cycle push or pop; words in flight SHALL be discarded.

Structure
REQ-031 No shared package is required; DATA_WIDTH and DEPTH SHALL be passed down as parameters.
REQ-032 One sub-module sync_fifo (parameters DATA_WIDTH, DEPTH; ports clk, rst, push, wdata, full, pop, rdata, empty) SHALL be instantiated twice.
REQ-033 The top level SHALL contain only select steering and ready logic.

Verification
REQ-034 Reset, then idle -> out0_valid=out1_valid=0, both data ports 0, in_ready=1.
REQ-035 Push 0xAAAA0001 with sel=1, then 0x55550000 with sel=0 -> out1 shows 0xAAAA0001 and out0 shows 0x55550000, each one cycle after its push.
REQ-036 With out1_ready=0, push 3 words with sel=1 (DEPTH=2) -> third word refused (in_ready=0); a simultaneous sel=0 push is accepted.
REQ-037 Both FIFOs full, pop and push on out0 in the same cycle -> push refused; the next cycle accepts the push; order is preserved.
REQ-038 Stream 10 words 0x1 to 0xA to out0 with out0_ready=1 -> emerges 0x1 to 0xA in order, pointers wrap, throughput 1 word per cycle.
REQ-039 Assert rst with both FIFOs holding words -> next cycle both valids are 0, counts are 0, and in_ready=1.
